uart_config_regfile: RTL and testbench

Parametrised successor of the UART configuration register bank: CPU-facing register file driving the UART datapath configuration, baud divisor, FIFO thresholds and interrupt logic. It replaces the tri-state data bus with split write/read buses and a read-valid strobe. It adds an atomic divisor update and a configuration-change handshake FSM with timeout and revert. It also adds sticky write-1-to-clear interrupt pending bits with a masked `irq_o`.

---
 rtl/uart_config_regfile_if.sv | 29 ++
 rtl/uart_config_regfile.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_uart_config_regfile.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_config_regfile_if.sv
// uart_config_regfile_if
// CPU register bus for the UART configuration register file: split write/read
// data, one-cycle strobes, registered read response and bus error pulse.
// Signals:
//   wr_i, rd_i   write / read strobes (one cycle each)
//   addr_i       register address
//   wdata_i      write data
//   rdata_o      read data, valid with rvalid_o
//   rvalid_o     read response strobe
//   error_o      one-cycle bus error pulse
interface uart_config_regfile_if;
  logic       wr_i;
  logic       rd_i;
  logic [3:0] addr_i;
  logic [7:0] wdata_i;
  logic [7:0] rdata_o;
  logic       rvalid_o;
  logic       error_o;

  modport master (
    output wr_i, rd_i, addr_i, wdata_i,
    input  rdata_o, rvalid_o, error_o
  );

  modport slave (
    input  wr_i, rd_i, addr_i, wdata_i,
    output rdata_o, rvalid_o, error_o
  );
endinterface

// File: rtl/uart_config_regfile.sv
// uart_config_regfile
// CPU-facing register bank for the UART: frame format with a link-layer
// change handshake, atomic baud divisor update, RX threshold, sticky
// interrupt pending bits and the RX/TX FIFO data windows.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   bus                               CPU register bus (slave modport)
//   data_width_o/parity_mode_o/stop_bits_o  active frame format
//   tx_dsm_o, rx_dsm_o                data-stream-mode bits
//   cfg_req_o, cfg_ack_i, cfg_nack_i  format change handshake
//   divisor_o, rx_threshold_o         baud divisor, RX FIFO threshold
//   tx_fifo_full_i, rx_fifo_empty_i   FIFO status
//   rx_data_i, rx_fifo_read_o         RX FIFO head / pop
//   tx_data_o, tx_fifo_write_o        TX FIFO data / push
//   rx_rdy_i, frame_err_i, parity_err_i, overrun_i  interrupt event pulses
//   irq_o                             masked interrupt request
//
// Config FSM
//   state  | meaning
//   S_IDLE | STR format equals active format, no request outstanding
//   S_REQ  | new format held in STR, cfg_req_o high, awaiting ack/nack/timeout
module uart_config_regfile #(
  parameter int          DIVISOR_WIDTH = 16,
  parameter int          THR_WIDTH     = 6,
  parameter logic [15:0] STD_DIVISOR   = 16'd27,
  parameter logic [5:0]  STD_FORMAT    = 6'b00_00_11,
  parameter int          CFG_TIMEOUT   = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  uart_config_regfile_if.slave     bus,
  output logic [1:0]               data_width_o,
  output logic [1:0]               parity_mode_o,
  output logic [1:0]               stop_bits_o,
  output logic                     tx_dsm_o,
  output logic                     rx_dsm_o,
  output logic                     cfg_req_o,
  input  logic                     cfg_ack_i,
  input  logic                     cfg_nack_i,
  output logic [DIVISOR_WIDTH-1:0] divisor_o,
  output logic [THR_WIDTH-1:0]     rx_threshold_o,
  input  logic                     tx_fifo_full_i,
  input  logic                     rx_fifo_empty_i,
  input  logic                     rx_rdy_i,
  input  logic                     frame_err_i,
  input  logic                     parity_err_i,
  input  logic                     overrun_i,
  output logic                     irq_o,
  input  logic [7:0]               rx_data_i,
  output logic                     rx_fifo_read_o,
  output logic [7:0]               tx_data_o,
  output logic                     tx_fifo_write_o
);

  localparam logic [3:0] A_STR  = 4'd0;
  localparam logic [3:0] A_LDVR = 4'd1;
  localparam logic [3:0] A_UDVR = 4'd2;
  localparam logic [3:0] A_FSR  = 4'd3;
  localparam logic [3:0] A_CTR  = 4'd4;
  localparam logic [3:0] A_IER  = 4'd5;
  localparam logic [3:0] A_RXR  = 4'd6;
  localparam logic [3:0] A_TXR  = 4'd7;
  localparam logic [3:0] A_IPR  = 4'd8;

  localparam int             TCW      = $clog2(CFG_TIMEOUT);
  localparam logic [TCW-1:0] TMO_LOAD = TCW'(CFG_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t                   r_state;
  logic [TCW-1:0]           r_tmo_cnt;
  logic [5:0]               r_str_fmt;
  logic [5:0]               r_act_fmt;
  logic                     r_tdsm;
  logic                     r_rdsm;
  logic [7:0]               r_div_stage;
  logic [DIVISOR_WIDTH-1:0] r_div;
  logic [THR_WIDTH-1:0]     r_thr;
  logic                     r_enreq;
  logic                     r_cdone;
  logic                     r_stdc;
  logic [4:0]               r_ier;
  logic [4:0]               r_ipr;
  logic [7:0]               r_txr;
  logic                     r_irq;
  logic [7:0]               r_rdata;
  logic                     r_rvalid;
  logic                     r_err;

  state_t w_state_nxt;
  logic   w_cfg_start;
  logic   w_direct;
  logic   w_ack_commit;
  logic   w_revert;
  logic   w_fmt_err;
  logic [7:0] w_rd_val;

  // A simultaneous read is dropped in favour of the write.
  logic w_wr, w_rd_ok, w_mapped;
  assign w_wr     = bus.wr_i;
  assign w_rd_ok  = bus.rd_i & ~bus.wr_i;
  assign w_mapped = (bus.addr_i <= A_IPR);

  logic w_wr_str, w_wr_ldvr, w_wr_udvr, w_wr_fsr, w_wr_ctr, w_wr_ier, w_wr_txr, w_wr_ipr;
  assign w_wr_str  = w_wr & (bus.addr_i == A_STR);
  assign w_wr_ldvr = w_wr & (bus.addr_i == A_LDVR);
  assign w_wr_udvr = w_wr & (bus.addr_i == A_UDVR);
  assign w_wr_fsr  = w_wr & (bus.addr_i == A_FSR);
  assign w_wr_ctr  = w_wr & (bus.addr_i == A_CTR);
  assign w_wr_ier  = w_wr & (bus.addr_i == A_IER);
  assign w_wr_txr  = w_wr & (bus.addr_i == A_TXR);
  assign w_wr_ipr  = w_wr & (bus.addr_i == A_IPR);

  logic [5:0] w_wfmt;
  logic       w_stdc_wr;
  assign w_wfmt    = bus.wdata_i[5:0];
  assign w_stdc_wr = w_wr_ctr & bus.wdata_i[4];

  logic w_tx_push, w_rx_pop;
  assign w_tx_push = w_wr_txr & ~tx_fifo_full_i;
  assign w_rx_pop  = w_rd_ok & (bus.addr_i == A_RXR) & ~rx_fifo_empty_i;

  logic [15:0] w_div_full;
  logic [15:0] w_div16;
  logic [5:0]  w_thr6;
  assign w_div_full = {bus.wdata_i, r_div_stage};
  assign w_div16    = 16'(r_div);
  assign w_thr6     = 6'(r_thr);

  // STDC preempts everything; ack beats nack/timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_cfg_start  = 1'b0;
    w_direct     = 1'b0;
    w_ack_commit = 1'b0;
    w_revert     = 1'b0;
    w_fmt_err    = 1'b0;
    if (w_stdc_wr) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_str && (w_wfmt != r_act_fmt)) begin
            if (r_enreq) begin
              w_cfg_start = 1'b1;
              w_state_nxt = S_REQ;
            end else begin
              w_direct = 1'b1;
            end
          end
        end
        S_REQ: begin
          if (w_wr_str && (w_wfmt != r_str_fmt)) w_fmt_err = 1'b1;
          if (cfg_ack_i) begin
            w_ack_commit = 1'b1;
            w_state_nxt  = S_IDLE;
          end else if (cfg_nack_i || (r_tmo_cnt == '0)) begin
            w_revert    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Timeout is a down-counter loaded on entry to S_REQ; zero is terminal.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cfg_start)
        r_tmo_cnt <= TMO_LOAD;
      else if ((r_state == S_REQ) && (r_tmo_cnt != '0))
        r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_str_fmt   <= STD_FORMAT;
      r_act_fmt   <= STD_FORMAT;
      r_tdsm      <= 1'b0;
      r_rdsm      <= 1'b0;
      r_div_stage <= 8'h00;
      r_div       <= STD_DIVISOR[DIVISOR_WIDTH-1:0];
      r_thr       <= '0;
      r_enreq     <= 1'b1;
      r_cdone     <= 1'b1;
      r_stdc      <= 1'b0;
      r_ier       <= 5'b01111;
      r_ipr       <= 5'b00000;
      r_txr       <= 8'h00;
      r_irq       <= 1'b0;
    end else begin
      r_stdc <= 1'b0;
      if (w_stdc_wr) begin
        r_str_fmt <= STD_FORMAT;
        r_act_fmt <= STD_FORMAT;
        r_cdone   <= 1'b1;
      end else begin
        // In S_REQ the pending format in STR is frozen.
        if (w_wr_str && (r_state == S_IDLE)) r_str_fmt <= w_wfmt;
        if (w_direct)    r_act_fmt <= w_wfmt;
        if (w_cfg_start) r_cdone   <= 1'b0;
        if (w_ack_commit) begin
          r_act_fmt <= r_str_fmt;
          r_cdone   <= 1'b1;
        end
        if (w_revert) begin
          r_str_fmt <= r_act_fmt;
          r_cdone   <= 1'b1;
        end
      end
      if (w_wr_str) begin
        r_rdsm <= bus.wdata_i[7];
        r_tdsm <= bus.wdata_i[6];
      end
      if (w_wr_ldvr) r_div_stage <= bus.wdata_i;
      if (w_wr_udvr) r_div <= w_div_full[DIVISOR_WIDTH-1:0];
      if (w_wr_fsr)  r_thr <= bus.wdata_i[THR_WIDTH-1:0];
      if (w_wr_ctr) begin
        r_enreq <= bus.wdata_i[5];
        r_stdc  <= bus.wdata_i[4];
      end
      if (w_wr_ier)  r_ier <= bus.wdata_i[4:0];
      if (w_tx_push) r_txr <= bus.wdata_i;
      // Set beats clear on the same bit.
      r_ipr <= (r_ipr & ~(w_wr_ipr ? bus.wdata_i[4:0] : 5'b00000))
             | {w_revert, overrun_i, parity_err_i, frame_err_i, rx_rdy_i};
      r_irq <= |(r_ipr & r_ier);
    end
  end

  always_comb begin
    w_rd_val = 8'h00;
    case (bus.addr_i)
      A_STR:   w_rd_val = {r_rdsm, r_tdsm, r_str_fmt};
      A_LDVR:  w_rd_val = w_div16[7:0];
      A_UDVR:  w_rd_val = w_div16[15:8];
      A_FSR:   w_rd_val = {tx_fifo_full_i, rx_fifo_empty_i, w_thr6};
      A_CTR:   w_rd_val = {1'b0, r_cdone, r_enreq, r_stdc, 4'b0000};
      A_IER:   w_rd_val = {3'b000, r_ier};
      A_RXR:   w_rd_val = rx_fifo_empty_i ? 8'h00 : rx_data_i;
      A_TXR:   w_rd_val = r_txr;
      A_IPR:   w_rd_val = {3'b000, r_ipr};
      default: w_rd_val = 8'h00;
    endcase
  end

  logic w_err;
  assign w_err = ((bus.wr_i | bus.rd_i) & ~w_mapped)
               | (bus.wr_i & bus.rd_i)
               | (w_wr_txr & tx_fifo_full_i)
               | (w_rd_ok & (bus.addr_i == A_RXR) & rx_fifo_empty_i)
               | w_fmt_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata  <= 8'h00;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      r_rdata  <= w_rd_ok ? w_rd_val : 8'h00;
      r_err    <= w_err;
    end
  end

  assign bus.rdata_o     = r_rdata;
  assign bus.rvalid_o    = r_rvalid;
  assign bus.error_o     = r_err;
  assign data_width_o    = r_act_fmt[1:0];
  assign parity_mode_o   = r_act_fmt[3:2];
  assign stop_bits_o     = r_act_fmt[5:4];
  assign tx_dsm_o        = r_tdsm;
  assign rx_dsm_o        = r_rdsm;
  assign cfg_req_o       = (r_state == S_REQ);
  assign divisor_o       = r_div;
  assign rx_threshold_o  = r_thr;
  assign irq_o           = r_irq;
  assign rx_fifo_read_o  = w_rx_pop;
  assign tx_data_o       = bus.wdata_i;
  assign tx_fifo_write_o = w_tx_push;

endmodule

// File: tb/tb_uart_config_regfile.sv
// tb_uart_config_regfile
// Directed walk through the register map and config handshake, followed by
// randomized bus traffic, all compared against a behavioural model.
module tb_uart_config_regfile;
  localparam int          DW   = 16;
  localparam int          TW   = 6;
  localparam int          TMO  = 20;
  localparam logic [5:0]  STDF = 6'b00_00_11;
  localparam logic [15:0] STDD = 16'd27;

  logic clk_i = 1'b0;
  logic rst_i;
  logic cfg_ack_i, cfg_nack_i, tx_fifo_full_i, rx_fifo_empty_i;
  logic rx_rdy_i, frame_err_i, parity_err_i, overrun_i;
  logic [7:0] rx_data_i;
  logic [1:0] data_width_o, parity_mode_o, stop_bits_o;
  logic tx_dsm_o, rx_dsm_o, cfg_req_o, irq_o, rx_fifo_read_o, tx_fifo_write_o;
  logic [DW-1:0] divisor_o;
  logic [TW-1:0] rx_threshold_o;
  logic [7:0] tx_data_o;

  int n_err = 0;
  int n_chk = 0;

  uart_config_regfile_if bus_if ();

  uart_config_regfile #(
    .DIVISOR_WIDTH(DW), .THR_WIDTH(TW), .STD_DIVISOR(STDD),
    .STD_FORMAT(STDF), .CFG_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus_if.slave),
    .data_width_o(data_width_o), .parity_mode_o(parity_mode_o), .stop_bits_o(stop_bits_o),
    .tx_dsm_o(tx_dsm_o), .rx_dsm_o(rx_dsm_o),
    .cfg_req_o(cfg_req_o), .cfg_ack_i(cfg_ack_i), .cfg_nack_i(cfg_nack_i),
    .divisor_o(divisor_o), .rx_threshold_o(rx_threshold_o),
    .tx_fifo_full_i(tx_fifo_full_i), .rx_fifo_empty_i(rx_fifo_empty_i),
    .rx_rdy_i(rx_rdy_i), .frame_err_i(frame_err_i), .parity_err_i(parity_err_i),
    .overrun_i(overrun_i), .irq_o(irq_o),
    .rx_data_i(rx_data_i), .rx_fifo_read_o(rx_fifo_read_o),
    .tx_data_o(tx_data_o), .tx_fifo_write_o(tx_fifo_write_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [5:0]  m_act, m_str;
  logic [1:0]  m_dsm;
  bit          m_req;
  int          m_age;
  logic [15:0] m_div;
  logic [7:0]  m_stage, m_txr, m_rdata;
  logic [5:0]  m_thr;
  logic [4:0]  m_ier, m_ipr;
  bit          m_enreq, m_cdone, m_stdc, m_irq, m_rvalid, m_err;
  logic        obs_txwr, obs_rxrd;

  task automatic model_reset();
    m_act = STDF; m_str = STDF; m_dsm = 2'b00; m_req = 0; m_age = 0;
    m_div = STDD; m_stage = 8'h00; m_thr = 6'd0; m_ier = 5'b01111; m_ipr = 5'd0;
    m_enreq = 1; m_cdone = 1; m_stdc = 0; m_txr = 8'h00; m_irq = 0;
    m_rvalid = 0; m_rdata = 8'h00; m_err = 0;
  endtask

  // One rising edge of the register file, computed from the current inputs.
  task automatic model_edge();
    logic       w, r, rd_ok, revert;
    logic [3:0] a;
    logic [7:0] d, rv;
    logic [4:0] clr;
    bit         err;
    w = bus_if.wr_i; r = bus_if.rd_i; a = bus_if.addr_i; d = bus_if.wdata_i;
    rd_ok = r && !w;
    err = ((w || r) && a > 4'd8) || (w && r);
    rv = 8'h00;
    if (rd_ok) begin
      case (a)
        4'd0: rv = {m_dsm, m_str};
        4'd1: rv = m_div[7:0];
        4'd2: rv = m_div[15:8];
        4'd3: rv = {tx_fifo_full_i, rx_fifo_empty_i, m_thr};
        4'd4: rv = {1'b0, m_cdone, m_enreq, m_stdc, 4'b0000};
        4'd5: rv = {3'b000, m_ier};
        4'd6: rv = rx_fifo_empty_i ? 8'h00 : rx_data_i;
        4'd7: rv = m_txr;
        4'd8: rv = {3'b000, m_ipr};
        default: rv = 8'h00;
      endcase
      if (a == 4'd6 && rx_fifo_empty_i) err = 1;
    end
    if (w && a == 4'd7 && tx_fifo_full_i) err = 1;
    m_irq = |(m_ipr & m_ier);
    revert = 0;
    if (w && a == 4'd4 && d[4]) begin
      m_str = STDF; m_act = STDF; m_cdone = 1; m_req = 0;
    end else if (m_req) begin
      if (w && a == 4'd0 && d[5:0] != m_str) err = 1;
      if (cfg_ack_i) begin
        m_act = m_str; m_cdone = 1; m_req = 0;
      end else if (cfg_nack_i || m_age == TMO - 1) begin
        m_str = m_act; m_cdone = 1; m_req = 0; revert = 1;
      end else begin
        m_age++;
      end
    end else if (w && a == 4'd0 && d[5:0] != m_act) begin
      m_str = d[5:0];
      if (m_enreq) begin
        m_req = 1; m_age = 0; m_cdone = 0;
      end else begin
        m_act = d[5:0];
      end
    end
    if (w && a == 4'd0) m_dsm = d[7:6];
    if (w && a == 4'd1) m_stage = d;
    if (w && a == 4'd2) m_div = {d, m_stage};
    if (w && a == 4'd3) m_thr = d[5:0];
    m_stdc = 0;
    if (w && a == 4'd4) begin m_enreq = d[5]; m_stdc = d[4]; end
    if (w && a == 4'd5) m_ier = d[4:0];
    if (w && a == 4'd7 && !tx_fifo_full_i) m_txr = d;
    clr = (w && a == 4'd8) ? d[4:0] : 5'd0;
    m_ipr = (m_ipr & ~clr) | {revert, overrun_i, parity_err_i, frame_err_i, rx_rdy_i};
    m_rvalid = rd_ok;
    m_rdata = rd_ok ? rv : 8'h00;
    m_err = err;
  endtask

  task automatic check_regs();
    chk("rvalid", 32'(bus_if.rvalid_o), 32'(m_rvalid));
    chk("rdata", 32'(bus_if.rdata_o), 32'(m_rdata));
    chk("error", 32'(bus_if.error_o), 32'(m_err));
    chk("data_width", 32'(data_width_o), 32'(m_act[1:0]));
    chk("parity_mode", 32'(parity_mode_o), 32'(m_act[3:2]));
    chk("stop_bits", 32'(stop_bits_o), 32'(m_act[5:4]));
    chk("tx_dsm", 32'(tx_dsm_o), 32'(m_dsm[0]));
    chk("rx_dsm", 32'(rx_dsm_o), 32'(m_dsm[1]));
    chk("cfg_req", 32'(cfg_req_o), 32'(m_req));
    chk("divisor", 32'(divisor_o), 32'(m_div));
    chk("rx_threshold", 32'(rx_threshold_o), 32'(m_thr));
    chk("irq", 32'(irq_o), 32'(m_irq));
  endtask

  task automatic cyc(input logic w, input logic r, input logic [3:0] a, input logic [7:0] d);
    bus_if.wr_i = w; bus_if.rd_i = r; bus_if.addr_i = a; bus_if.wdata_i = d;
    #1;
    obs_txwr = tx_fifo_write_o;
    obs_rxrd = rx_fifo_read_o;
    chk("tx_fifo_write", 32'(tx_fifo_write_o), 32'(w && a == 4'd7 && !tx_fifo_full_i));
    chk("rx_fifo_read", 32'(rx_fifo_read_o), 32'(r && !w && a == 4'd6 && !rx_fifo_empty_i));
    chk("tx_data", 32'(tx_data_o), 32'(d));
    @(posedge clk_i);
    model_edge();
    #1;
    check_regs();
    bus_if.wr_i = 0; bus_if.rd_i = 0;
    cfg_ack_i = 0; cfg_nack_i = 0;
    rx_rdy_i = 0; frame_err_i = 0; parity_err_i = 0; overrun_i = 0;
  endtask

  initial begin
    int n;
    rst_i = 1;
    bus_if.wr_i = 0; bus_if.rd_i = 0; bus_if.addr_i = 0; bus_if.wdata_i = 0;
    cfg_ack_i = 0; cfg_nack_i = 0; tx_fifo_full_i = 0; rx_fifo_empty_i = 0;
    rx_rdy_i = 0; frame_err_i = 0; parity_err_i = 0; overrun_i = 0; rx_data_i = 8'h00;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_regs();
    chk("rst_div", 32'(divisor_o), 32'd27);
    chk("rst_fmt", 32'({stop_bits_o, parity_mode_o, data_width_o}), 32'h03);
    rst_i = 0;

    // Divisor staging and atomic commit
    cyc(1, 0, 4'd1, 8'h34);
    chk("div_hold", 32'(divisor_o), 32'd27);
    cyc(1, 0, 4'd2, 8'h12);
    chk("div_commit", 32'(divisor_o), 32'h1234);
    cyc(0, 1, 4'd1, 8'h00);
    chk("ldvr_rd", 32'(bus_if.rdata_o), 32'h34);

    // Format change acknowledged
    cyc(1, 0, 4'd0, 8'h16);
    chk("ack_req_hi", 32'(cfg_req_o), 32'd1);
    chk("ack_fmt_hold", 32'({stop_bits_o, parity_mode_o, data_width_o}), 32'h03);
    cyc(0, 1, 4'd4, 8'h00);
    chk("ctr_cdone0", 32'(bus_if.rdata_o), 32'h20);
    cfg_ack_i = 1;
    cyc(0, 0, 4'd0, 8'h00);
    chk("ack_req_lo", 32'(cfg_req_o), 32'd0);
    chk("ack_fmt", 32'({data_width_o, parity_mode_o, stop_bits_o}), 32'b10_01_01);
    cyc(0, 1, 4'd4, 8'h00);
    chk("ctr_cdone1", 32'(bus_if.rdata_o), 32'h60);

    // STDC in idle restores standard format
    cyc(1, 0, 4'd4, 8'h30);
    chk("stdc_idle_fmt", 32'({stop_bits_o, parity_mode_o, data_width_o}), 32'h03);

    // Timeout with no ack
    cyc(1, 0, 4'd0, 8'h16);
    n = 0;
    for (int k = 0; k < TMO + 10 && cfg_req_o; k++) begin
      cyc(0, 0, 4'd0, 8'h00);
      if (cfg_req_o) n++;
    end
    chk("tmo_req_drop", 32'(cfg_req_o), 32'd0);
    chk("tmo_len", 32'(n), 32'(TMO - 1));
    cyc(0, 1, 4'd0, 8'h00);
    chk("tmo_str_revert", 32'(bus_if.rdata_o), 32'h03);
    cyc(0, 1, 4'd8, 8'h00);
    chk("tmo_cfgerr", 32'(bus_if.rdata_o), 32'h10);
    chk("tmo_irq_masked", 32'(irq_o), 32'd0);
    cyc(1, 0, 4'd5, 8'h1F);
    cyc(0, 0, 4'd0, 8'h00);
    chk("tmo_irq", 32'(irq_o), 32'd1);
    cyc(1, 0, 4'd8, 8'h10);
    cyc(0, 0, 4'd0, 8'h00);
    chk("tmo_irq_clr", 32'(irq_o), 32'd0);

    // STDC aborts a pending request
    cyc(1, 0, 4'd0, 8'h16);
    cyc(1, 0, 4'd4, 8'h30);
    chk("stdc_abort_req", 32'(cfg_req_o), 32'd0);
    chk("stdc_abort_fmt", 32'({stop_bits_o, parity_mode_o, data_width_o}), 32'h03);
    cyc(0, 0, 4'd0, 8'h00);
    cyc(0, 1, 4'd4, 8'h00);
    chk("stdc_selfclr", 32'(bus_if.rdata_o), 32'h60);
    cyc(0, 1, 4'd8, 8'h00);
    chk("stdc_no_cfgerr", 32'(bus_if.rdata_o), 32'h00);

    // STR write while a request is pending
    cyc(1, 0, 4'd0, 8'h16);
    cyc(1, 0, 4'd0, 8'h25);
    chk("req_str_err", 32'(bus_if.error_o), 32'd1);
    chk("req_str_fmt", 32'({stop_bits_o, parity_mode_o, data_width_o}), 32'h03);
    cyc(0, 1, 4'd0, 8'h00);
    chk("req_str_keep", 32'(bus_if.rdata_o), 32'h16);
    cfg_nack_i = 1;
    cyc(0, 0, 4'd0, 8'h00);
    chk("nack_req_lo", 32'(cfg_req_o), 32'd0);
    cyc(0, 1, 4'd8, 8'h00);
    chk("nack_cfgerr", 32'(bus_if.rdata_o), 32'h10);
    cyc(1, 0, 4'd8, 8'h1F);

    // Set wins over clear; masked interrupts stay quiet
    parity_err_i = 1;
    cyc(1, 0, 4'd8, 8'h04);
    cyc(0, 1, 4'd8, 8'h00);
    chk("par_set_wins", 32'(bus_if.rdata_o), 32'h04);
    cyc(1, 0, 4'd5, 8'h00);
    cyc(0, 0, 4'd0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      rx_rdy_i = 1; overrun_i = 1; frame_err_i = 1;
      cyc(0, 0, 4'd0, 8'h00);
      chk("irq_masked", 32'(irq_o), 32'd0);
    end
    cyc(1, 0, 4'd8, 8'h1F);
    cyc(1, 0, 4'd5, 8'h0F);

    // FIFO windows and bus errors
    rx_fifo_empty_i = 1; rx_data_i = 8'h5A;
    cyc(0, 1, 4'd6, 8'h00);
    chk("rxr_empty_nopop", 32'(obs_rxrd), 32'd0);
    chk("rxr_empty_data", 32'(bus_if.rdata_o), 32'h00);
    chk("rxr_empty_err", 32'(bus_if.error_o), 32'd1);
    rx_fifo_empty_i = 0;
    cyc(0, 1, 4'd6, 8'h00);
    chk("rxr_pop", 32'(obs_rxrd), 32'd1);
    chk("rxr_data", 32'(bus_if.rdata_o), 32'h5A);
    tx_fifo_full_i = 1;
    cyc(1, 0, 4'd7, 8'hAA);
    chk("txr_full_nopush", 32'(obs_txwr), 32'd0);
    chk("txr_full_err", 32'(bus_if.error_o), 32'd1);
    tx_fifo_full_i = 0;
    cyc(1, 0, 4'd7, 8'hC3);
    chk("txr_push", 32'(obs_txwr), 32'd1);
    cyc(0, 1, 4'd7, 8'h00);
    chk("txr_readback", 32'(bus_if.rdata_o), 32'hC3);
    cyc(1, 1, 4'd5, 8'h0F);
    chk("wr_rd_err", 32'(bus_if.error_o), 32'd1);
    chk("wr_rd_norvalid", 32'(bus_if.rvalid_o), 32'd0);
    cyc(1, 0, 4'd12, 8'h55);
    chk("unmapped_wr_err", 32'(bus_if.error_o), 32'd1);
    cyc(0, 1, 4'd12, 8'h00);
    chk("unmapped_rd_err", 32'(bus_if.error_o), 32'd1);
    chk("unmapped_rd_data", 32'(bus_if.rdata_o), 32'h00);

    // Reset in the middle of a request
    cyc(1, 0, 4'd0, 8'h16);
    chk("mid_req_hi", 32'(cfg_req_o), 32'd1);
    rst_i = 1;
    #1;
    chk("rst_async_req", 32'(cfg_req_o), 32'd0);
    model_reset();
    check_regs();
    @(posedge clk_i);
    #1;
    rst_i = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       w, r;
      logic [3:0] a;
      logic [7:0] d;
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      d = 8'($urandom);
      if (a == 4'd4 && $urandom_range(0, 3) != 0) d[4] = 1'b0;
      tx_fifo_full_i  = ($urandom_range(0, 3) == 0);
      rx_fifo_empty_i = ($urandom_range(0, 3) == 0);
      rx_data_i       = 8'($urandom);
      cfg_ack_i       = ($urandom_range(0, 24) == 0);
      cfg_nack_i      = ($urandom_range(0, 39) == 0);
      rx_rdy_i        = ($urandom_range(0, 15) == 0);
      frame_err_i     = ($urandom_range(0, 15) == 0);
      parity_err_i    = ($urandom_range(0, 15) == 0);
      overrun_i       = ($urandom_range(0, 15) == 0);
      cyc(w, r, a, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
